// File: rtl/io_out_buf_if.sv
// Valid/ready stream carrying {address, data} entries from the output buffer
// to the output peripherals.
interface io_out_buf_if #(
    parameter int unsigned NUBITS = 32,
    parameter int unsigned NUIOOU = 8
);
    localparam int unsigned AW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    logic              valid;
    logic              ready;
    logic [AW-1:0]     addr;
    logic [NUBITS-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/io_out_buf.sv
// Output-I/O stage: queues core output writes in a first-word fall-through FIFO
// drained over a valid/ready stream, and keeps a shadow copy of every output port.
module io_out_buf #(
    parameter int unsigned NUBITS = 32,
    parameter int unsigned NUIOOU = 8,
    parameter int unsigned FAW    = 3,
    localparam int unsigned AW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     out_en_i,
    input  logic [AW-1:0]            addr_out_i,
    input  logic [NUBITS-1:0]        data_out_i,
    io_out_buf_if.master             m_if,
    output logic                     full_o,
    output logic [FAW:0]             count_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i,
    output logic [NUIOOU*NUBITS-1:0] port_q_o
);
    localparam int unsigned DEPTH   = 2 ** FAW;
    localparam int unsigned EW      = AW + NUBITS;
    localparam logic [FAW:0] FullCnt = {1'b1, {FAW{1'b0}}};

    logic [EW-1:0]     mem_q [DEPTH];
    logic [FAW-1:0]    wptr_q, wptr_d;
    logic [FAW-1:0]    rptr_q, rptr_d;
    logic [FAW:0]      count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [NUBITS-1:0] port_q [NUIOOU];

    logic push, pop, full;

    assign full = (count_q == FullCnt);
    assign pop  = m_if.valid && m_if.ready;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign push = out_en_i && (!full || pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Set wins over clear so a drop on the clearing edge is not lost.
        if (out_en_i && !push) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push) begin
                mem_q[wptr_q] <= {addr_out_i, data_out_i};
            end
        end
    end

    // Shadow update ignores FIFO state; out-of-range addresses match no word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUIOOU; i++) begin
                port_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUIOOU; i++) begin
                if (out_en_i && (addr_out_i == AW'(i))) begin
                    port_q[i] <= data_out_i;
                end
            end
        end
    end

    always_comb begin
        port_q_o = '0;
        for (int unsigned i = 0; i < NUIOOU; i++) begin
            port_q_o[i*NUBITS +: NUBITS] = port_q[i];
        end
    end

    assign m_if.valid = (count_q != '0);
    assign m_if.addr  = mem_q[rptr_q][EW-1:NUBITS];
    assign m_if.data  = mem_q[rptr_q][NUBITS-1:0];
    assign full_o     = full;
    assign count_o    = count_q;
    assign ovf_o      = ovf_q;
endmodule
